fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4; beats (64-bit, two instructions each) per read burst; power of two, 1..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000; fetch address after reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 arvalid  out  1  AXI read-address valid.
REQ-006 arready  in  1  AXI read-address ready.
REQ-007 araddr  out  32  burst start address, 8-byte aligned.
REQ-008 arlen  out  8  beats minus one.
REQ-009 arsize  out  3  constant 3'b011.
REQ-010 arburst  out  2  constant 2'b01 (INCR).
REQ-011 rvalid  in  1  AXI read-data valid.
REQ-012 rlast  in  1  AXI last beat.
REQ-013 rready  out  1  AXI read-data ready.
REQ-014 buf_free  in  8  free entries in the instruction buffer.
REQ-015 redirect_valid  in  1  jump accepted; refetch from redirect_pc.
REQ-016 redirect_pc  in  32  redirect target.
REQ-017 fetch_pc  out  32  address of the current beat's first instruction.
REQ-018 buf_write  out  1  current beat is to be written to the buffer.
REQ-019 flush  out  1  one-cycle pulse; buffer contents are to be discarded.

Function
REQ-020 SHALL implement states IDLE, ADDR, DATA, DRAIN.
REQ-021 Counters and addresses:
- pc register holds the next fetch address.
- beats = min(BURST_LEN, (4096 - pc[11:0]) / 8) with pc[2:0] cleared; a burst never crosses a 4 KB boundary.
- arlen = beats - 1.
REQ-022 IDLE -> ADDR when buf_free >= beats and no redirect this cycle; araddr latched = {pc[31:3],3'b000}, arlen latched.
REQ-023 ADDR:
- arvalid=1; araddr/arlen held stable until arvalid & arready.
- On handshake -> DATA, or -> DRAIN if a redirect is pending or arrives that cycle.
REQ-024 DATA:
- rready=1.
- Each rvalid beat: buf_write=1, fetch_pc = beat address, beat address += 8.
- rvalid & rlast -> IDLE with pc = araddr + 8*beats.
REQ-025 DRAIN: rready=1, buf_write=0; rvalid & rlast -> IDLE with pc = pending target.
REQ-026 Redirect handling (redirect_valid high in any state):
- flush=1 the same cycle.
- Target stored as pending; a later redirect overwrites it (latest wins).
- IDLE: pc = redirect_pc next cycle, stay IDLE.
- DATA, no rlast that cycle: -> DRAIN, current beat buf_write=0.
- DATA with rvalid & rlast same cycle: beat discarded, -> IDLE with pc=redirect_pc.
REQ-027 SHALL never deassert arvalid before its handshake, including on redirect.
REQ-028 rready=0 in IDLE and ADDR; a beat arriving there is ignored.
REQ-029 fetch_pc holds its last value when buf_write=0.
REQ-030 Address arithmetic SHALL be 32-bit modulo 2^32 (wraps at 32'hFFFF_FFF8 + 8).
REQ-031 Single outstanding burst only; no new AR until the current burst's rlast is consumed.

Reset
REQ-032 When rst_n=0 at a rising edge:
- state=IDLE, pc=RESET_PC, pending cleared.
- arvalid=0, rready=0, buf_write=0, flush=0, araddr=0, arlen=0, fetch_pc=RESET_PC.
REQ-033 Reset mid-burst SHALL abandon the burst without draining; the AXI slave is reset by the same rst_n.

Verification
REQ-034 Reset, buf_free=8, arready=1, 4 beats, rlast on beat 4 -> AR araddr=0 arlen=3; buf_write on 4 beats with fetch_pc 0,8,16,24; next AR araddr=32.
REQ-035 pc=32'h0000_0FF0, BURST_LEN=4 -> arlen=1 (2 beats); following AR araddr=32'h0000_1000 arlen=3.
REQ-036 buf_free=3 in IDLE -> arvalid stays 0; buf_free=4 -> arvalid=1 the next cycle.
REQ-037 Redirect to 32'h100 after beat 2 of 4 -> flush pulse; beats 3-4 accepted with buf_write=0; next AR araddr=32'h100.
REQ-038 Redirect to 32'h200 while arvalid=1, arready=0 for 3 cycles -> arvalid and araddr held; after handshake all beats drained; next AR araddr=32'h200.
REQ-039 rst_n=0 during beat 2 -> all outputs at reset values the next cycle; next AR araddr=RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
module fetch_ctrl #(
  parameter int unsigned BURST_LEN = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        rvalid,
  input  logic        rlast,
  output logic        rready,
  input  logic [7:0]  buf_free,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_pc,
  output logic        buf_write,
  output logic        flush
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend_valid;
  logic [31:0] beat_addr;
  logic [31:0] fetch_pc_q;

  logic [31:0] pc_base;
  logic [9:0]  room;
  logic [4:0]  beats;
  logic [31:0] burst_end;

  always_comb begin
    pc_base   = pc & 32'hFFFF_FFF8;
    // 8-byte slots left before the next 4 KB boundary (1..512)
    room      = 10'd512 - {1'b0, pc[11:3]};
    beats     = (room > 10'(BURST_LEN)) ? 5'(BURST_LEN) : room[4:0];
    burst_end = araddr + ({21'd0, arlen, 3'b000} + 32'd8);
  end

  assign arsize    = 3'b011;
  assign arburst   = 2'b01;
  assign flush     = redirect_valid;
  assign buf_write = (state == DATA) && rvalid && !redirect_valid;
  assign fetch_pc  = buf_write ? beat_addr : fetch_pc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      araddr     <= '0;
      arlen      <= '0;
      beat_addr  <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      if (buf_write)
        fetch_pc_q <= beat_addr;

      case (state)
        IDLE: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (buf_free >= {3'b000, beats}) begin
            state     <= ADDR;
            arvalid   <= 1'b1;
            araddr    <= pc_base;
            arlen     <= {3'b000, beats} - 8'd1;
            beat_addr <= pc_base;
          end
        end

        ADDR: begin
          if (redirect_valid) begin
            pend_pc    <= redirect_pc;
            pend_valid <= 1'b1;
          end
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= (pend_valid || redirect_valid) ? DRAIN : DATA;
          end
        end

        DATA: begin
          if (rvalid)
            beat_addr <= beat_addr + 32'd8;
          if (rvalid && rlast) begin
            state      <= IDLE;
            rready     <= 1'b0;
            pend_valid <= 1'b0;
            pc         <= redirect_valid ? redirect_pc : burst_end;
          end else if (redirect_valid) begin
            state      <= DRAIN;
            pend_pc    <= redirect_pc;
            pend_valid <= 1'b1;
          end
        end

        DRAIN: begin
          if (rvalid && rlast) begin
            state      <= IDLE;
            rready     <= 1'b0;
            pend_valid <= 1'b0;
            pc         <= redirect_valid ? redirect_pc : pend_pc;
          end else if (redirect_valid) begin
            pend_pc <= redirect_pc;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam int unsigned BL  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic [7:0]  buf_free;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_pc;
  logic        buf_write;
  logic        flush;

  fetch_ctrl #(.BURST_LEN(BL), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .buf_free(buf_free),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_pc(fetch_pc), .buf_write(buf_write), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  ar_t         exp_ar[$];
  logic [31:0] exp_wr[$];
  int unsigned exp_fl[$];
  logic [31:0] last_wr;
  logic [31:0] mon_e;
  int unsigned mon_c;
  logic [31:0] mpc;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: event absent within bound (cycle %0d)", name, cyc);
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: beats in a burst starting at p, capped by the 4 KB page end
  function automatic int beats_for(input logic [31:0] p);
    int off;
    int room;
    off  = int'(p[11:0]);
    off  = off - (off % 8);
    room = (4096 - off) / 8;
    return (room < int'(BL)) ? room : int'(BL);
  endfunction

  // Monitor: pops expectations whenever the DUT presents AR, a buffer write or a flush
  always @(negedge clk) begin
    if (!rst_n) begin
      last_wr = RPC;
    end else begin
      if (arvalid) begin
        if (exp_ar.size() == 0) begin
          fail_now("unexpected_ar");
        end else begin
          check32("araddr", araddr, exp_ar[0].addr);
          check32("arlen", 32'(arlen), 32'(exp_ar[0].len));
          if (arready) begin
            check32("arsize", 32'(arsize), 32'd3);
            check32("arburst", 32'(arburst), 32'd1);
            void'(exp_ar.pop_front());
          end
        end
      end
      if (buf_write) begin
        if (exp_wr.size() == 0) begin
          fail_now("unexpected_write");
        end else begin
          mon_e = exp_wr.pop_front();
          check32("fetch_pc", fetch_pc, mon_e);
          last_wr = mon_e;
        end
      end else begin
        check32("fetch_pc_hold", fetch_pc, last_wr);
      end
      if (flush) begin
        if (exp_fl.size() == 0) begin
          fail_now("unexpected_flush");
        end else begin
          mon_c = exp_fl.pop_front();
          check32("flush_cycle", cyc, mon_c);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_arvalid"},   32'(arvalid),   32'd0);
    check32({tag, "_rready"},    32'(rready),    32'd0);
    check32({tag, "_buf_write"}, 32'(buf_write), 32'd0);
    check32({tag, "_flush"},     32'(flush),     32'd0);
    check32({tag, "_araddr"},    araddr,         32'd0);
    check32({tag, "_arlen"},     32'(arlen),     32'd0);
    check32({tag, "_fetch_pc"},  fetch_pc,       RPC);
  endtask

  // mode: 0 plain, 1 redirect in IDLE, 2 redirect during AR, 3 redirect during data, 4 reset on beat 2
  task automatic run_burst(input int mode, input logic [31:0] tgt, input int kin,
                           input bit two, input logic [31:0] tgt2);
    int          n;
    int          k;
    int          stall;
    int          rc;
    int          waits;
    bit          drain;
    logic [31:0] base;

    if (mode == 1) begin
      buf_free       = 8'($urandom_range(0, 255));
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      exp_fl.push_back(cyc);
      tick();
      redirect_valid = 1'b0;
      mpc            = tgt;
    end

    n    = beats_for(mpc);
    base = mpc & 32'hFFFF_FFF8;
    k    = (kin < 0) ? int'($urandom_range(0, n - 1)) : ((kin > n - 1) ? n - 1 : kin);

    buf_free = 8'(n - 1);
    tick();
    check32("ar_low_1", 32'(arvalid), 32'd0);
    check32("rready_idle", 32'(rready), 32'd0);
    tick();
    check32("ar_low_2", 32'(arvalid), 32'd0);

    exp_ar.push_back('{addr: base, len: 8'(n - 1)});
    buf_free = 8'($urandom_range(n, n + 8));
    tick();
    check32("ar_issue", 32'(arvalid), 32'd1);
    waits = 0;
    while (!arvalid && waits < 8) begin
      tick();
      waits++;
    end
    if (!arvalid) begin
      fail_now("ar_timeout");
      finish_run();
    end
    buf_free = 8'd0;

    stall = (mode == 2) ? 3 : int'($urandom_range(0, 3));
    rc    = int'($urandom_range(0, 3));
    for (int s = 0; s <= stall; s++) begin
      arready = (s == stall);
      if (mode == 2 && s == rc) begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_fl.push_back(cyc);
      end
      tick();
      redirect_valid = 1'b0;
    end
    arready = 1'b0;
    drain   = (mode == 2);
    if (mode == 2) mpc = tgt;

    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      waits = 0;
      while (!rready && waits < 8) begin
        tick();
        waits++;
      end
      if (!rready) begin
        fail_now("rready_timeout");
        finish_run();
      end
      rvalid = 1'b1;
      rlast  = (i == n - 1);
      if (mode == 4 && i == 1) begin
        rst_n = 1'b0;
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_ar.delete();
        exp_wr.delete();
        exp_fl.delete();
        mpc   = RPC;
        rst_n = 1'b1;
        return;
      end
      if (mode == 3 && i == k) begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_fl.push_back(cyc);
        drain = 1'b1;
        mpc   = tgt;
      end else if (mode == 3 && two && i == k + 1) begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt2;
        exp_fl.push_back(cyc);
        mpc = tgt2;
      end
      if (!drain) exp_wr.push_back(base + 32'(8 * i));
      tick();
      rvalid         = 1'b0;
      rlast          = 1'b0;
      redirect_valid = 1'b0;
    end
    if (!drain) mpc = base + 32'(8 * n);

    check32("wr_left", 32'(exp_wr.size()), 32'd0);
    check32("ar_left", 32'(exp_ar.size()), 32'd0);
    check32("flush_left", 32'(exp_fl.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    fail_now("watchdog");
    finish_run();
  end

  initial begin
    rst_n          = 1'b0;
    arready        = 1'b0;
    rvalid         = 1'b0;
    rlast          = 1'b0;
    buf_free       = 8'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    mpc   = RPC;

    for (int it = 0; it < 60; it++) begin
      int          mode;
      int          kin;
      bit          two;
      logic [31:0] tgt;
      logic [31:0] tgt2;
      tgt  = $urandom;
      if ($urandom_range(0, 2) == 0) tgt[11:0] = 12'(12'hFC0 + $urandom_range(0, 63));
      tgt2 = $urandom;
      kin  = -1;
      two  = ($urandom_range(0, 1) == 1);
      mode = int'($urandom_range(0, 9));
      mode = (mode > 4) ? mode - 5 : mode;
      case (it)
        0: mode = 0;
        1: begin mode = 1; tgt = 32'h0000_0FF0; end
        2: mode = 0;
        3: begin mode = 3; tgt = 32'h0000_0100; kin = 2; two = 1'b0; end
        4: begin mode = 2; tgt = 32'h0000_0200; end
        5: mode = 4;
        6: begin mode = 1; tgt = 32'hFFFF_FFF8; end
        7: mode = 0;
        8: begin mode = 3; kin = 99; two = 1'b0; end
        9: begin mode = 3; kin = 0; two = 1'b1; end
        default: ;
      endcase
      run_burst(mode, tgt, kin, two, tgt2);
    end

    tick();
    tick();
    finish_run();
  end

endmodule
